// File: rtl/h_ram_arb.sv
// Round-robin arbiter sharing one single-port synchronous RAM among N requesters.
// After reset the RAM is zero-filled before any requester is granted.
module h_ram_arb #(
    parameter int N     = 4,
    parameter int DEPTH = 256,
    parameter int DW    = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            arst_n,
    input  logic [N-1:0]    req_vld,
    input  logic [N-1:0]    req_wen,
    input  logic [N*AW-1:0] req_addr,
    input  logic [N*DW-1:0] req_wdata,
    output logic [N-1:0]    req_rdy,
    output logic [N-1:0]    rsp_vld,
    output logic [DW-1:0]   rsp_rdata,
    output logic            init_done,
    output logic            ram_en,
    output logic            ram_wen,
    output logic [AW-1:0]   ram_addr,
    output logic [DW-1:0]   ram_wdata,
    input  logic [DW-1:0]   ram_rdata
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  cnt_q, cnt_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [N-1:0]   rsp_vld_q, rsp_vld_d;

    logic [N-1:0]   gnt_s;
    logic           gnt_found_s;
    logic [PW-1:0]  gnt_idx_s;
    logic           ram_en_s;
    logic           ram_wen_s;
    logic [AW-1:0]  ram_addr_s;
    logic [DW-1:0]  ram_wdata_s;

    logic [AW-1:0]  addr_a  [N];
    logic [DW-1:0]  wdata_a [N];

    // Unpack the flat request buses into per-requester arrays.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            addr_a[i]  = req_addr[i*AW +: AW];
            wdata_a[i] = req_wdata[i*DW +: DW];
        end
    end

    // Round-robin search starting at ptr_q; only grants while running.
    always_comb begin
        logic [PW:0]   sum_v;
        logic [PW-1:0] idx_v;
        logic          hit_v;
        gnt_s       = '0;
        gnt_found_s = 1'b0;
        gnt_idx_s   = '0;
        sum_v       = '0;
        idx_v       = '0;
        hit_v       = 1'b0;
        for (int k = 0; k < N; k++) begin
            sum_v       = {1'b0, ptr_q} + (PW+1)'(k);
            idx_v       = (sum_v >= (PW+1)'(N)) ? PW'(sum_v - (PW+1)'(N)) : PW'(sum_v);
            hit_v       = (state_q == ST_RUN) && !gnt_found_s && req_vld[idx_v];
            gnt_s[idx_v] = hit_v;
            gnt_idx_s   = hit_v ? idx_v : gnt_idx_s;
            gnt_found_s = gnt_found_s | hit_v;
        end
    end

    // Next-state, RAM drive and read-response tracking.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        rsp_vld_d   = '0;
        ram_en_s    = 1'b0;
        ram_wen_s   = 1'b0;
        ram_addr_s  = '0;
        ram_wdata_s = '0;
        case (state_q)
            ST_INIT: begin
                ram_en_s   = 1'b1;
                ram_wen_s  = 1'b1;
                ram_addr_s = cnt_q;
                cnt_d      = cnt_q + AW'(1);
                if (cnt_q == AW'(DEPTH - 1)) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (gnt_found_s) begin
                    ram_en_s    = 1'b1;
                    ram_wen_s   = req_wen[gnt_idx_s];
                    ram_addr_s  = addr_a[gnt_idx_s];
                    ram_wdata_s = wdata_a[gnt_idx_s];
                    rsp_vld_d   = gnt_s & ~req_wen;
                    ptr_d       = (gnt_idx_s == PW'(N - 1)) ? '0 : gnt_idx_s + PW'(1);
                end else begin
                    ptr_d = ptr_q;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    // State, fill counter, round-robin pointer and pending read responses.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            ptr_q     <= '0;
            rsp_vld_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ptr_q     <= ptr_d;
            rsp_vld_q <= rsp_vld_d;
        end
    end

    // INIT drives the RAM from reset state, so gate the enables while reset is held.
    assign ram_en    = ram_en_s & arst_n;
    assign ram_wen   = ram_wen_s & arst_n;
    assign ram_addr  = ram_addr_s;
    assign ram_wdata = ram_wdata_s;
    assign req_rdy   = gnt_s;
    assign rsp_vld   = rsp_vld_q;
    assign rsp_rdata = ram_rdata;
    assign init_done = (state_q == ST_RUN);

endmodule
